// File: rtl/regfile_pkg.sv
// Shared defaults, architectural register indices and address type for the register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 16;
  localparam int REGFILE_ADDR_W = 4;

  typedef logic [REGFILE_ADDR_W-1:0] rf_addr_t;

  localparam rf_addr_t R_ZERO = 4'd0;
  localparam rf_addr_t R_RA   = 4'd2;
  localparam rf_addr_t R_IH   = 4'd13;
  localparam rf_addr_t R_T    = 4'd14;
  localparam rf_addr_t R_SP   = 4'd15;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits; flush beats issue, issue beats WB clear on the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 iss_en_i,
  input  logic [ADDR_W-1:0]    iss_addr_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  output logic [2**ADDR_W-1:0] pend_o,
  output logic                 iss_ready_o
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                iss_zero, wr_zero, iss_acc;

  assign iss_zero    = ZERO_REG && (iss_addr_i == '0);
  assign wr_zero     = ZERO_REG && (wr_addr_i == '0);
  // Ready ignores same-cycle WB on purpose: no combinational WB->ID path.
  assign iss_ready_o = ~pend_q[iss_addr_i];
  assign iss_acc     = iss_en_i && iss_ready_o && !iss_zero;

  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (wr_en_i && !wr_zero) pend_d[wr_addr_i] = 1'b0;
      if (iss_acc)             pend_d[iss_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard; two combinational read ports, one WB write port.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle WB write onto the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic              rd_busy_a_o,
  output logic              rd_busy_b_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              iss_en_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  output logic              iss_ready_o,
  input  logic              flush_i
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic                iss_ready;
  logic                wr_valid;
  logic [DATA_W-1:0]   base_a, base_b;

  assign wr_valid = wr_en_i && !(ZERO_REG && (wr_addr_i == '0));

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .iss_en_i    (iss_en_i),
    .iss_addr_i  (iss_addr_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .pend_o      (pend),
    .iss_ready_o (iss_ready)
  );

  assign iss_ready_o = iss_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (wr_valid) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign base_a = (ZERO_REG && (rd_addr_a_i == '0)) ? '0 : mem_q[rd_addr_a_i];
  assign base_b = (ZERO_REG && (rd_addr_b_i == '0)) ? '0 : mem_q[rd_addr_b_i];

`ifdef REGFILE_BYPASS_EN
  logic iss_acc;

  // Mirrors the scoreboard's accept so a forwarded read still shows busy for a new producer.
  assign iss_acc = iss_en_i && iss_ready && !flush_i && !(ZERO_REG && (iss_addr_i == '0));

  always_comb begin
    rd_data_a_o = base_a;
    rd_busy_a_o = pend[rd_addr_a_i];
    rd_data_b_o = base_b;
    rd_busy_b_o = pend[rd_addr_b_i];
    if (!rst_i && wr_valid && (wr_addr_i == rd_addr_a_i)) begin
      rd_data_a_o = wr_data_i;
      rd_busy_a_o = iss_acc && (iss_addr_i == rd_addr_a_i);
    end
    if (!rst_i && wr_valid && (wr_addr_i == rd_addr_b_i)) begin
      rd_data_b_o = wr_data_i;
      rd_busy_b_o = iss_acc && (iss_addr_i == rd_addr_b_i);
    end
  end
`else
  assign rd_data_a_o = base_a;
  assign rd_data_b_o = base_b;
  assign rd_busy_a_o = pend[rd_addr_a_i];
  assign rd_busy_b_o = pend[rd_addr_b_i];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb; expectations queued by stimulus, checked at negedge.
module tb_regfile_sb;

  localparam int K_DA = 0, K_BA = 1, K_DB = 2, K_BB = 3, K_IR = 4;

  typedef struct {
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        clk, rst;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, iss_addr;
  logic [15:0] rd_data_a, rd_data_b, wr_data;
  logic        rd_busy_a, rd_busy_b, wr_en, iss_en, iss_ready, flush;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (rd_data_a),
    .rd_data_b_o (rd_data_b),
    .rd_busy_a_o (rd_busy_a),
    .rd_busy_b_o (rd_busy_b),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .iss_en_i    (iss_en),
    .iss_addr_i  (iss_addr),
    .iss_ready_o (iss_ready),
    .flush_i     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input int kind, input logic [15:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  // Monitor: everything queued before a negedge is compared against the outputs at that negedge.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_DA:    act = rd_data_a;
          K_BA:    act = {15'd0, rd_busy_a};
          K_DB:    act = rd_data_b;
          K_BB:    act = {15'd0, rd_busy_b};
          default: act = {15'd0, iss_ready};
        endcase
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst = 1'b1;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    wr_addr = 4'd0; wr_data = 16'h0;
    iss_addr = 4'd7;
    idle();
    #2;
    expect_v(K_BA, 16'd0, "reset_busy_a");
    expect_v(K_IR, 16'd1, "reset_iss_ready");
    step();
    rst = 1'b0;
    step();

    // write/read, R0 hardwired
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    step();
    idle(); rd_addr_a = 4'd3;
    expect_v(K_DA, 16'hBEEF, "r3_read");
    step();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234;
    step();
    idle(); rd_addr_a = 4'd0;
    expect_v(K_DA, 16'h0000, "r0_read_zero");
    step();

    // issue R7, then WB clears it
    iss_en = 1'b1; iss_addr = 4'd7;
    expect_v(K_IR, 16'd1, "r7_ready_before");
    step();
    idle(); rd_addr_a = 4'd7;
    expect_v(K_BA, 16'd1, "r7_busy");
    expect_v(K_IR, 16'd0, "r7_not_ready");
    step();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA; rd_addr_b = 4'd7;
`ifdef REGFILE_BYPASS_EN
    expect_v(K_DB, 16'h00AA, "r7_wb_cycle_data_b");
    expect_v(K_BB, 16'd0, "r7_wb_cycle_busy_b");
`else
    expect_v(K_DB, 16'h0000, "r7_wb_cycle_data_b");
    expect_v(K_BB, 16'd1, "r7_wb_cycle_busy_b");
`endif
    step();
    idle();
    expect_v(K_BA, 16'd0, "r7_cleared");
    expect_v(K_DA, 16'h00AA, "r7_data");
    expect_v(K_IR, 16'd1, "r7_ready_after");
    step();

    // R4: WAW stall while pending, then WB + issue same address keeps it pending
    iss_en = 1'b1; iss_addr = 4'd4;
    step();
    idle();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h1111;
    iss_en = 1'b1; iss_addr = 4'd4; rd_addr_b = 4'd4;
    expect_v(K_IR, 16'd0, "r4_waw_stall");
`ifdef REGFILE_BYPASS_EN
    expect_v(K_DB, 16'h1111, "r4_stall_data_b");
    expect_v(K_BB, 16'd0, "r4_stall_busy_b");
`else
    expect_v(K_DB, 16'h0000, "r4_stall_data_b");
    expect_v(K_BB, 16'd1, "r4_stall_busy_b");
`endif
    step();
    wr_data = 16'h2222;
    expect_v(K_IR, 16'd1, "r4_ready_again");
`ifdef REGFILE_BYPASS_EN
    expect_v(K_DB, 16'h2222, "r4_wb_iss_data_b");
    expect_v(K_BB, 16'd1, "r4_wb_iss_busy_b");
`else
    expect_v(K_DB, 16'h1111, "r4_wb_iss_data_b");
    expect_v(K_BB, 16'd0, "r4_wb_iss_busy_b");
`endif
    step();
    idle(); rd_addr_a = 4'd4;
    expect_v(K_BA, 16'd1, "r4_stays_pending");
    expect_v(K_DA, 16'h2222, "r4_data");
    step();

    // flush with pending R2/R9/R15/R4, concurrent issue R6 and WB R3
    iss_en = 1'b1; iss_addr = 4'd2; step();
    iss_addr = 4'd9; step();
    iss_addr = 4'd15; step();
    idle(); rd_addr_a = 4'd15; rd_addr_b = 4'd9;
    expect_v(K_BA, 16'd1, "r15_busy_pre_flush");
    expect_v(K_BB, 16'd1, "r9_busy_pre_flush");
    flush = 1'b1; iss_en = 1'b1; iss_addr = 4'd6;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h3333;
    step();
    idle();
    rd_addr_a = 4'd2; rd_addr_b = 4'd9;
    expect_v(K_BA, 16'd0, "r2_flushed");
    expect_v(K_BB, 16'd0, "r9_flushed");
    step();
    rd_addr_a = 4'd15; rd_addr_b = 4'd6;
    expect_v(K_BA, 16'd0, "r15_flushed");
    expect_v(K_BB, 16'd0, "r6_not_pending");
    step();
    rd_addr_a = 4'd4; rd_addr_b = 4'd3;
    expect_v(K_BA, 16'd0, "r4_flushed");
    expect_v(K_DB, 16'h3333, "r3_write_during_flush");
    expect_v(K_IR, 16'd1, "r6_ready");
    step();

    // RAW on R5 during its WB cycle
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0505;
    step();
    idle(); iss_en = 1'b1; iss_addr = 4'd5;
    step();
    idle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h5A5A; rd_addr_b = 4'd5;
`ifdef REGFILE_BYPASS_EN
    expect_v(K_DB, 16'h5A5A, "r5_raw_data_b");
    expect_v(K_BB, 16'd0, "r5_raw_busy_b");
`else
    expect_v(K_DB, 16'h0505, "r5_raw_data_b");
    expect_v(K_BB, 16'd1, "r5_raw_busy_b");
`endif
    step();
    idle();
    expect_v(K_DB, 16'h5A5A, "r5_after_wb");
    expect_v(K_BB, 16'd0, "r5_busy_after_wb");
    step();

    // asynchronous reset mid-cycle discards a write to R5 and an issue of R8
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hDEAD;
    iss_en = 1'b1; iss_addr = 4'd8;
    rd_addr_a = 4'd3; rd_addr_b = 4'd5;
    #2;
    rst = 1'b1;
    #1;
    expect_v(K_DA, 16'h0000, "rst_async_r3");
    expect_v(K_DB, 16'h0000, "rst_async_r5_b");
    expect_v(K_BB, 16'd0, "rst_async_busy_b");
    expect_v(K_IR, 16'd1, "rst_async_ready");
    step();
    idle();
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = i[3:0];
      expect_v(K_DA, 16'h0000, $sformatf("rst_data_r%0d", i));
      expect_v(K_BA, 16'd0, $sformatf("rst_busy_r%0d", i));
      step();
    end
    rst = 1'b0;
    rd_addr_a = 4'd5; rd_addr_b = 4'd8; iss_addr = 4'd8;
    expect_v(K_DA, 16'h0000, "r5_write_lost");
    expect_v(K_BB, 16'd0, "r8_issue_lost");
    expect_v(K_IR, 16'd1, "r8_ready_after_rst");
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
